avalon_timer_slave: RTL and testbench

- Memory-mapped interval timer; Avalon-MM responder to the Nios II data master inside `system`.
- Software programs a period and prescaler, then starts the timer. The block counts down, sets a sticky timeout flag and raises an interrupt.
- Supports one-shot and continuous modes.
- A 1-cycle timeout pulse is exported as a conduit for LEDs and the parallel port.

---
 rtl/timer_pkg.sv | 17 +
 rtl/timer_prescaler.sv | 26 ++
 rtl/avalon_timer_slave.sv | 96 +++++++++
 tb/tb_avalon_timer_slave.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: register map, CTRL bit positions and run-state encoding for the interval timer.
package timer_pkg;

   localparam logic [2:0] ADDR_CTRL     = 3'd0;
   localparam logic [2:0] ADDR_STATUS   = 3'd1;
   localparam logic [2:0] ADDR_PERIOD   = 3'd2;
   localparam logic [2:0] ADDR_COUNT    = 3'd3;
   localparam logic [2:0] ADDR_PRESCALE = 3'd4;

   localparam int CTRL_START  = 0;
   localparam int CTRL_STOP   = 1;
   localparam int CTRL_CONT   = 2;
   localparam int CTRL_IRQ_EN = 3;

   typedef enum logic {IDLE, RUN} timer_state_t;

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: reloadable down-counter; ticks on the enabled cycle where it sits at zero.
module timer_prescaler #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] reload,
   output logic         tick
);

   logic [W-1:0] cnt;

   assign tick = en && cnt == '0;

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= reload;
      else if (en)
         cnt <= tick ? reload : cnt - W'(1);
   end

endmodule

// File: rtl/avalon_timer_slave.sv
// avalon_timer_slave: Avalon-MM interval timer with one-shot/continuous modes,
// sticky timeout flag, level interrupt and a one-cycle timeout conduit pulse.
module avalon_timer_slave
   import timer_pkg::*;
#(
   parameter int          COUNT_W    = 32,
   parameter int          PRESC_W    = 16,
   parameter logic [31:0] PERIOD_RST = 32'd49999
) (
   input  logic        clk_clk,
   input  logic        reset_reset,
   input  logic [2:0]  avs_address,
   input  logic        avs_read,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   output logic [31:0] avs_readdata,
   output logic        avs_readdatavalid,
   output logic        irq,
   output logic        timeout_export
);

   timer_state_t       state;
   logic               cont, irq_en, to;
   logic [COUNT_W-1:0] period, count;
   logic [PRESC_W-1:0] prescale;
   logic               tick, wr_ctrl, wr_status, start, stop, expire;
   logic [31:0]        rdata;

   assign wr_ctrl   = avs_write && avs_address == ADDR_CTRL;
   assign wr_status = avs_write && avs_address == ADDR_STATUS;
   assign start     = wr_ctrl && avs_writedata[CTRL_START];
   assign stop      = wr_ctrl && avs_writedata[CTRL_STOP];
   // A START or STOP strobe pre-empts a tick landing in the same cycle.
   assign expire    = state == RUN && tick && count == '0 && !start && !stop;
   assign irq       = to && irq_en;

   timer_prescaler #(.W(PRESC_W)) u_presc (
      .clk    (clk_clk),
      .rst    (reset_reset),
      .load   (start),
      .en     (state == RUN),
      .reload (prescale),
      .tick   (tick)
   );

   always_comb begin
      rdata = avs_address == ADDR_CTRL     ? {28'b0, irq_en, cont, 2'b0} :
              avs_address == ADDR_STATUS   ? {30'b0, state == RUN, to} :
              avs_address == ADDR_PERIOD   ? 32'(period) :
              avs_address == ADDR_COUNT    ? 32'(count) :
              avs_address == ADDR_PRESCALE ? 32'(prescale) : 32'b0;
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state             <= IDLE;
         cont              <= 1'b0;
         irq_en            <= 1'b0;
         to                <= 1'b0;
         period            <= COUNT_W'(PERIOD_RST);
         prescale          <= '0;
         count             <= '0;
         timeout_export    <= 1'b0;
         avs_readdata      <= 32'b0;
         avs_readdatavalid <= 1'b0;
      end else begin
         avs_readdatavalid <= avs_read;
         if (avs_read)
            avs_readdata <= rdata;
         timeout_export <= expire;
         to <= expire || (to && !wr_status);
         if (wr_ctrl) begin
            cont   <= avs_writedata[CTRL_CONT];
            irq_en <= avs_writedata[CTRL_IRQ_EN];
         end
         if (avs_write && avs_address == ADDR_PERIOD)
            period <= avs_writedata[COUNT_W-1:0];
         if (avs_write && avs_address == ADDR_PRESCALE)
            prescale <= avs_writedata[PRESC_W-1:0];
         if (stop)
            state <= IDLE;
         else if (start) begin
            state <= RUN;
            count <= period;
         end else if (state == RUN && tick) begin
            if (count != '0)
               count <= count - COUNT_W'(1);
            else if (cont)
               count <= period;
            else
               state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_avalon_timer_slave.sv
// tb_avalon_timer_slave: directed and randomized bus traffic against an arithmetic
// model that derives COUNT and timeout instants from elapsed cycles since each reload.
module tb_avalon_timer_slave;

   logic        clk_clk = 1'b0;
   logic        reset_reset = 1'b1;
   logic [2:0]  avs_address = '0;
   logic        avs_read = 1'b0;
   logic        avs_write = 1'b0;
   logic [31:0] avs_writedata = '0;
   logic [31:0] avs_readdata;
   logic        avs_readdatavalid;
   logic        irq;
   logic        timeout_export;

   int vectors = 0;
   int errors = 0;

   avalon_timer_slave dut (
      .clk_clk           (clk_clk),
      .reset_reset       (reset_reset),
      .avs_address       (avs_address),
      .avs_read          (avs_read),
      .avs_write         (avs_write),
      .avs_writedata     (avs_writedata),
      .avs_readdata      (avs_readdata),
      .avs_readdatavalid (avs_readdatavalid),
      .irq               (irq),
      .timeout_export    (timeout_export)
   );

   always #5 clk_clk = ~clk_clk;

   // Model: a running segment started at edge seg_start with period seg_p and
   // prescale seg_s; COUNT and the timeout instant follow from elapsed cycles.
   bit     m_run, m_to, m_cont, m_irq_en, m_rdv, m_pulse;
   longint m_period, m_prescale, m_frozen, m_seg_start, m_seg_p, m_seg_s, m_n;
   logic [31:0] m_rd;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic longint cur_count();
      longint k = m_n - m_seg_start;
      return m_run ? m_seg_p - k / (m_seg_s + 1) : m_frozen;
   endfunction

   function automatic bit will_expire();
      longint k = m_n - m_seg_start;
      return m_run && (k + 1) == (m_seg_p + 1) * (m_seg_s + 1);
   endfunction

   function automatic logic [31:0] read_val(input logic [2:0] a);
      case (a)
         3'd0:    return {28'b0, m_irq_en, m_cont, 2'b0};
         3'd1:    return {30'b0, m_run, m_to};
         3'd2:    return 32'(m_period);
         3'd3:    return 32'(cur_count());
         3'd4:    return 32'(m_prescale);
         default: return 32'b0;
      endcase
   endfunction

   task automatic model_reset();
      m_run = 0; m_to = 0; m_cont = 0; m_irq_en = 0; m_rdv = 0; m_pulse = 0;
      m_period = 49999; m_prescale = 0; m_frozen = 0; m_rd = 0;
      m_seg_start = 0; m_seg_p = 0; m_seg_s = 0;
   endtask

   task automatic model_edge(input bit r, input bit w, input logic [2:0] a,
                             input logic [31:0] d, input bit rs);
      bit st, sp, ex, old_cont;
      longint cc, old_p, old_s;
      if (rs) begin
         model_reset();
         m_n++;
         return;
      end
      m_rdv = r;
      if (r) m_rd = read_val(a);
      st = w && a == 3'd0 && d[0];
      sp = w && a == 3'd0 && d[1];
      ex = will_expire() && !st && !sp;
      cc = cur_count();
      old_p = m_period; old_s = m_prescale; old_cont = m_cont;
      m_pulse = ex;
      m_to = ex || (m_to && !(w && a == 3'd1));
      if (w && a == 3'd0) begin m_cont = d[2]; m_irq_en = d[3]; end
      if (w && a == 3'd2) m_period = longint'(d);
      if (w && a == 3'd4) m_prescale = longint'(d[15:0]);
      m_n++;
      if (sp) begin
         if (m_run) m_frozen = cc;
         m_run = 0;
      end else if (st) begin
         m_run = 1; m_seg_start = m_n; m_seg_p = old_p; m_seg_s = old_s;
      end else if (ex) begin
         if (old_cont) begin m_seg_start = m_n; m_seg_p = old_p; end
         else begin m_run = 0; m_frozen = 0; end
      end
   endtask

   task automatic step(input bit r, input bit w, input logic [2:0] a,
                       input logic [31:0] d, input bit rs);
      avs_read = r; avs_write = w; avs_address = a; avs_writedata = d; reset_reset = rs;
      @(posedge clk_clk);
      model_edge(r, w, a, d, rs);
      #1;
      chk("rdvalid", {31'b0, avs_readdatavalid}, {31'b0, m_rdv});
      if (m_rdv) chk($sformatf("rdata[a%0d]", a), avs_readdata, m_rd);
      if (rs) chk("rst_rdata", avs_readdata, 32'b0);
      chk("irq", {31'b0, irq}, {31'b0, m_to && m_irq_en});
      chk("timeout", {31'b0, timeout_export}, {31'b0, m_pulse});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 3'd0, 32'b0, 0);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      step(0, 1, a, d, 0);
   endtask

   task automatic rd(input logic [2:0] a);
      step(1, 0, a, 32'b0, 0);
   endtask

   initial begin
      bit r, w, rs;
      logic [2:0] a;
      logic [31:0] d;
      model_reset();
      m_n = 0;
      step(0, 0, 3'd0, 32'b0, 1);
      step(0, 0, 3'd0, 32'b0, 1);
      for (int i = 0; i < 8; i++) rd(3'(i));
      idle(1);
      // one-shot with interrupt
      wr(3'd2, 32'd4); wr(3'd4, 32'd0); wr(3'd0, 32'h9);
      idle(6);
      rd(3'd1); wr(3'd1, 32'd0); idle(1); rd(3'd1);
      // continuous, prescaled, no interrupt
      wr(3'd2, 32'd2); wr(3'd4, 32'd3); wr(3'd0, 32'h5);
      for (int i = 0; i < 38; i++) rd(3'd3);
      wr(3'd0, 32'h2);
      // STOP at COUNT=7, then restart
      wr(3'd2, 32'd20); wr(3'd4, 32'd0); wr(3'd0, 32'h5);
      for (int i = 0; i < 40 && cur_count() != 7; i++) idle(1);
      wr(3'd0, 32'h6);
      rd(3'd3); rd(3'd1); idle(8); rd(3'd3);
      wr(3'd0, 32'h5); rd(3'd3); rd(3'd3); wr(3'd0, 32'h2);
      // STATUS write coinciding with a timeout
      wr(3'd2, 32'd3); wr(3'd4, 32'd1); wr(3'd0, 32'h9);
      for (int i = 0; i < 40; i++) begin
         if (will_expire()) begin wr(3'd1, 32'd0); break; end
         idle(1);
      end
      rd(3'd1); wr(3'd1, 32'd0); rd(3'd1);
      // START|STOP from idle, PERIOD change while running, reset mid-count
      wr(3'd0, 32'h3); rd(3'd1);
      wr(3'd2, 32'd6); wr(3'd0, 32'h5); idle(2); wr(3'd2, 32'd2);
      for (int i = 0; i < 20; i++) rd(3'd3);
      step(0, 0, 3'd0, 32'b0, 1);
      rd(3'd1); rd(3'd2); rd(3'd3);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rs = $urandom_range(0, 99) == 0;
         r = $urandom_range(0, 1);
         w = $urandom_range(0, 2) == 0;
         a = 3'($urandom_range(0, 7));
         d = $urandom;
         if (a == 3'd0) d = {28'b0, 4'($urandom_range(0, 15))} & ($urandom_range(0, 3) == 0 ? 32'hF : 32'hE);
         if (a == 3'd2) d = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 7));
         if (a == 3'd4) begin
            d = 32'($urandom_range(0, 3));
            if (m_run) a = 3'd5;
         end
         step(r, w, a, d, rs);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
